noaa_stats_engine: RTL and testbench

Parametrised next-generation NOAA IoT mote statistics engine. It requests temperature samples from the sensor front-end on a programmable cadence and accumulates a window of WIN unsigned readings. It then reports the windowed average, population standard deviation, or optionally the minimum or maximum. It replaces the fixed 12-bit, average/SD-only mote block, and adds configurable width, window depth, sample rate, and two extra statistics.

---
 rtl/noaa_stats_engine.sv | 169 ++++++++++++++++
 tb/tb_noaa_stats_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/noaa_stats_engine.sv
// Windowed statistics engine: requests WIN samples at a SAMPLE_DIV cadence and reports
// average, population SD, or (with NOAA_MINMAX_EN defined) the window minimum/maximum.
module noaa_stats_engine #(
    parameter int DATA_W     = 12,
    parameter int WIN        = 8,
    parameter int SAMPLE_DIV = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] TN,
    output logic              SAMPLE,
    output logic              DONE,
    output logic [DATA_W-1:0] AVG_SD
);

    localparam int LW  = $clog2(WIN);
    localparam int DW  = $clog2(SAMPLE_DIV);
    localparam int S1W = DATA_W + LW;
    localparam int S2W = 2 * DATA_W + LW;
    localparam int RW  = DATA_W + 2;
    localparam int BW  = $clog2(DATA_W + 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(SAMPLE_DIV - 2);
    localparam logic [LW-1:0] CNT_LAST = LW'(WIN - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {ACCUM, CALC, SQRT, OUT} state_t;

    state_t              state;
    logic [DW-1:0]       div_cnt;
    logic [LW-1:0]       smp_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [1:0]          mode_q;
    logic [S1W-1:0]      s1;
    logic [S2W-1:0]      s2;
    logic [2*DATA_W-1:0] sq_op;
    logic [RW-1:0]       sq_rem;
    logic [DATA_W-1:0]   sq_root;

    logic [1:0]          mode_eff;
    logic [2*DATA_W-1:0] tn_ext;
    logic [2*DATA_W-1:0] tn_sq;
    logic [DATA_W-1:0]   mean;
    logic [2*DATA_W-1:0] mean_ext;
    logic [2*DATA_W-1:0] mean_sq;
    logic [2*DATA_W-1:0] var_w;
    logic [RW+1:0]       rem_sh;
    logic [RW+1:0]       trial;
    logic [RW+1:0]       rem_nx;
    logic                sq_ge;
    logic [DATA_W-1:0]   root_nx;
    logic [DATA_W-1:0]   calc_res;
    logic                unused_bits;

`ifdef NOAA_MINMAX_EN
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;
    assign mode_eff    = MODE;
    assign unused_bits = ^{s1[LW-1:0], s2[LW-1:0], rem_nx[RW+1:RW]};
`else
    // Without the trackers MODE[1] is dropped: 10 acts as avg, 11 as SD.
    assign mode_eff    = {1'b0, MODE[0]};
    assign unused_bits = ^{MODE[1], s1[LW-1:0], s2[LW-1:0], rem_nx[RW+1:RW]};
`endif

    assign tn_ext   = {{DATA_W{1'b0}}, TN};
    assign tn_sq    = tn_ext * tn_ext;
    assign mean     = s1[S1W-1:LW];
    assign mean_ext = {{DATA_W{1'b0}}, mean};
    assign mean_sq  = mean_ext * mean_ext;
    // floor(S2/N) >= floor(S1/N)^2 always holds, so this never wraps.
    assign var_w    = s2[S2W-1:LW] - mean_sq;

    // One restoring-sqrt step: bring down two operand bits, try (root<<2)|1.
    assign rem_sh  = {sq_rem, sq_op[2*DATA_W-1 -: 2]};
    assign trial   = {2'b00, sq_root, 2'b01};
    assign sq_ge   = (rem_sh >= trial);
    assign rem_nx  = sq_ge ? (rem_sh - trial) : rem_sh;
    assign root_nx = {sq_root[DATA_W-2:0], sq_ge};

    always_comb begin
        calc_res = mean;
`ifdef NOAA_MINMAX_EN
        if (mode_q == 2'b10) calc_res = min_q;
        else if (mode_q == 2'b11) calc_res = max_q;
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ACCUM;
            div_cnt <= '0;
            smp_cnt <= '0;
            bit_cnt <= '0;
            mode_q  <= '0;
            s1      <= '0;
            s2      <= '0;
            sq_op   <= '0;
            sq_rem  <= '0;
            sq_root <= '0;
            SAMPLE  <= 1'b0;
            DONE    <= 1'b0;
            AVG_SD  <= '0;
`ifdef NOAA_MINMAX_EN
            min_q   <= '1;
            max_q   <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (SAMPLE) begin
                        div_cnt <= '0;
                        SAMPLE  <= 1'b0;
                        smp_cnt <= smp_cnt + 1'b1;
                        s1      <= s1 + {{LW{1'b0}}, TN};
                        s2      <= s2 + {{LW{1'b0}}, tn_sq};
                        if (smp_cnt == '0) mode_q <= mode_eff;
`ifdef NOAA_MINMAX_EN
                        if (TN < min_q) min_q <= TN;
                        if (TN > max_q) max_q <= TN;
`endif
                        if (smp_cnt == CNT_LAST) state <= CALC;
                    end else begin
                        // SAMPLE is registered, so it is raised one count early.
                        div_cnt <= div_cnt + 1'b1;
                        SAMPLE  <= (div_cnt == DIV_PRE);
                    end
                end
                CALC: begin
                    if (mode_q == 2'b01) begin
                        sq_op   <= var_w;
                        sq_rem  <= '0;
                        sq_root <= '0;
                        bit_cnt <= '0;
                        state   <= SQRT;
                    end else begin
                        AVG_SD <= calc_res;
                        DONE   <= 1'b1;
                        state  <= OUT;
                    end
                end
                SQRT: begin
                    sq_op   <= {sq_op[2*DATA_W-3:0], 2'b00};
                    sq_rem  <= rem_nx[RW-1:0];
                    sq_root <= root_nx;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        AVG_SD <= root_nx;
                        DONE   <= 1'b1;
                        state  <= OUT;
                    end
                end
                OUT: begin
                    DONE    <= 1'b0;
                    smp_cnt <= '0;
                    s1      <= '0;
                    s2      <= '0;
`ifdef NOAA_MINMAX_EN
                    min_q   <= '1;
                    max_q   <= '0;
`endif
                    state   <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_noaa_stats_engine.sv
// Directed bench for noaa_stats_engine: table of windows with hand-computed results,
// plus reset-mid-window and MODE-latch sequences. Min/max rows depend on NOAA_MINMAX_EN.
module tb_noaa_stats_engine;

    localparam int DATA_W = 12;
    localparam int WIN    = 8;
    localparam int SDIV   = 4;
    localparam int LAT_A  = 2;
    localparam int LAT_SD = 2 + DATA_W;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [1:0]        MODE = 2'b00;
    logic [DATA_W-1:0] TN = '0;
    logic              SAMPLE;
    logic              DONE;
    logic [DATA_W-1:0] AVG_SD;

    typedef struct {
        string                 name;
        logic [1:0]            mode;
        logic [1:0]            mode_mid;
        logic [WIN*DATA_W-1:0] tns;
        logic [DATA_W-1:0]     exp;
        int                    lat;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] exp_q[$];
    int                n_checks = 0;
    int                n_fail = 0;

    noaa_stats_engine #(.DATA_W(DATA_W), .WIN(WIN), .SAMPLE_DIV(SDIV)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .MODE   (MODE),
        .TN     (TN),
        .SAMPLE (SAMPLE),
        .DONE   (DONE),
        .AVG_SD (AVG_SD)
    );

    // clock / reset-independent global guard
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached, required $finish earlier");
        $fatal(1, "timeout");
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            n_checks++;
            if (SAMPLE && DONE) begin
                n_fail++;
                $display("FAIL sample_done_overlap: SAMPLE=%0b DONE=%0b required not both 1", SAMPLE, DONE);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] m, input logic [1:0] mm,
                           input int t0, input int t1, input int t2, input int t3,
                           input int t4, input int t5, input int t6, input int t7,
                           input int e, input int lat);
        vec_t v;
        int   t[WIN];
        t = '{t0, t1, t2, t3, t4, t5, t6, t7};
        v.name = name;
        v.mode = m;
        v.mode_mid = mm;
        for (int i = 0; i < WIN; i++) v.tns[i*DATA_W +: DATA_W] = t[i][DATA_W-1:0];
        v.exp = e[DATA_W-1:0];
        v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic wait_sample(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!SAMPLE && n < 200);
        if (!SAMPLE) check("sample_timeout", {31'd0, SAMPLE}, 1);
    endtask

    // Drives one window; returns one cycle after DONE, after checking the pulse width.
    task automatic run_window(input vec_t v);
        int                n;
        logic [DATA_W-1:0] e;
        exp_q.push_back(v.exp);
        for (int i = 0; i < WIN; i++) begin
            wait_sample(n);
            if (i == 0) check({v.name, "_first_sample_gap"}, n, SDIV - 1);
            else        check({v.name, "_sample_period"}, n, SDIV);
            if (i == 0) MODE = v.mode;
            if (i == 3) MODE = v.mode_mid;
            TN = v.tns[i*DATA_W +: DATA_W];
        end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 100);
        check({v.name, "_latency"}, n, v.lat);
        e = exp_q.pop_front();
        check({v.name, "_value"}, {20'd0, AVG_SD}, {20'd0, e});
        @(negedge CLK);
        check({v.name, "_done_pulse"}, {31'd0, DONE}, 0);
        check({v.name, "_avg_sd_hold"}, {20'd0, AVG_SD}, {20'd0, e});
    endtask

    initial begin
        int   n;
        vec_t post;

        add_vec("avg_const", 2'b00, 2'b00, 100, 100, 100, 100, 100, 100, 100, 100, 100, LAT_A);
        add_vec("sd_basic", 2'b01, 2'b01, 2, 4, 4, 4, 5, 5, 7, 9, 2, LAT_SD);
        add_vec("sd_fullscale", 2'b01, 2'b01, 0, 4095, 0, 4095, 0, 4095, 0, 4095, 2047, LAT_SD);
        add_vec("mode_latch_avg", 2'b00, 2'b01, 1, 2, 3, 4, 5, 6, 7, 8, 4, LAT_A);
        add_vec("mode_latch_next_sd", 2'b01, 2'b01, 1, 2, 3, 4, 5, 6, 7, 8, 3, LAT_SD);
`ifdef NOAA_MINMAX_EN
        add_vec("max", 2'b11, 2'b11, 7, 4095, 0, 12, 300, 5, 9, 1, 4095, LAT_A);
        add_vec("min", 2'b10, 2'b10, 7, 4095, 0, 12, 300, 5, 9, 1, 0, LAT_A);
`else
        add_vec("mode11_as_sd", 2'b11, 2'b11, 2, 4, 4, 4, 5, 5, 7, 9, 2, LAT_SD);
        add_vec("mode10_as_avg", 2'b10, 2'b10, 1, 2, 3, 4, 5, 6, 7, 8, 4, LAT_A);
`endif

        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_sample", {31'd0, SAMPLE}, 0);
        check("reset_done", {31'd0, DONE}, 0);
        check("reset_avg_sd", {20'd0, AVG_SD}, 0);
        RESET_N = 1'b1;

        for (int k = 0; k < vecs.size(); k++) run_window(vecs[k]);

        // Reset in the middle of a window: five samples of 50, then reset while SAMPLE is up.
        MODE = 2'b00;
        for (int i = 0; i < 5; i++) begin
            wait_sample(n);
            TN = 12'd50;
        end
        wait_sample(n);
        RESET_N = 1'b0;
        #1;
        check("midrst_sample", {31'd0, SAMPLE}, 0);
        check("midrst_done", {31'd0, DONE}, 0);
        check("midrst_avg_sd", {20'd0, AVG_SD}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        post.name = "post_reset_avg";
        post.mode = 2'b00;
        post.mode_mid = 2'b00;
        for (int i = 0; i < WIN; i++) post.tns[i*DATA_W +: DATA_W] = 12'd10;
        post.exp = 12'd10;
        post.lat = LAT_A;
        run_window(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
